// File: rtl/longop_sequencer.sv
// Issue sequencer for long-latency execute units: start pulse, PC hold, single writeback strobe, abort on flush.
// Latency: accept -> start 1 cycle, done -> wb_valid 1 cycle (minimum accept -> wb_valid is 3 cycles).
// Backpressure: stall blocks accept and holds WB; done is always sampled; LONGOP_TIMEOUT_EN adds a WAIT watchdog and err_timeout.
module longop_sequencer #(
   parameter int NUM_UNITS      = 2,
   parameter int MODE_W         = 2,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int UNIT_W        = $clog2(NUM_UNITS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic [UNIT_W-1:0]    req_unit,
   input  logic [MODE_W-1:0]    req_mode,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic [NUM_UNITS-1:0] unit_start,
   output logic [MODE_W-1:0]    unit_mode,
   output logic [NUM_UNITS-1:0] unit_abort,
   output logic                 pc_hold,
   output logic                 wb_valid,
   output logic [UNIT_W-1:0]    wb_sel,
   output logic                 busy,
`ifdef LONGOP_TIMEOUT_EN
   output logic                 req_illegal,
   output logic                 err_timeout
`else
   output logic                 req_illegal
`endif
);

   // Unit indices are compared one bit wider so a non-power-of-two unit count can flag illegal targets.
   localparam logic [UNIT_W:0] UNIT_LIMIT = (UNIT_W + 1)'(NUM_UNITS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   // Reject parameter sets the sequencer cannot support.
   if (NUM_UNITS < 2) begin : g_bad_num_units
      $error("longop_sequencer: NUM_UNITS must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("longop_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   state_t              state_q, state_d;
   logic [UNIT_W-1:0]   sel_q, sel_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [NUM_UNITS-1:0] sel_onehot;
   logic                req_legal;
   logic                done_sel;

`ifdef LONGOP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;

   assign err_timeout = err_q;
`endif

   // Decode the latched unit index once; all per-unit strobes and done selection use it.
   always_comb begin
      sel_onehot = {{(NUM_UNITS-1){1'b0}}, 1'b1} << sel_q;
      done_sel   = |(unit_done & sel_onehot);
      req_legal  = ({1'b0, req_unit} < UNIT_LIMIT);
   end

   // Registered state, latched unit select and mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
      end
   end

`ifdef LONGOP_TIMEOUT_EN
   // Watchdog counter and sticky timeout flag; only reset clears the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   // Next-state and output decode; flush outranks done, done outranks the watchdog.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      mode_d      = mode_q;
      unit_start  = '0;
      unit_abort  = '0;
      pc_hold     = 1'b0;
      wb_valid    = 1'b0;
      wb_sel      = '0;
      req_illegal = 1'b0;
`ifdef LONGOP_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (!req_legal) begin
                  req_illegal = 1'b1;
               end else if (!stall && !flush) begin
                  sel_d   = req_unit;
                  mode_d  = req_mode;
                  pc_hold = 1'b1;
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            pc_hold = 1'b1;
            if (flush) begin
               unit_abort = sel_onehot;
               state_d    = S_IDLE;
            end else begin
               unit_start = sel_onehot;
               state_d    = S_WAIT;
`ifdef LONGOP_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end

         S_WAIT: begin
            pc_hold = 1'b1;
            if (flush) begin
               unit_abort = sel_onehot;
               state_d    = S_IDLE;
            end else if (done_sel) begin
               state_d = S_WB;
`ifdef LONGOP_TIMEOUT_EN
            end else if (cnt_q == CNT_LIMIT) begin
               unit_abort = sel_onehot;
               err_d      = 1'b1;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end

         S_WB: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (stall) begin
               pc_hold = 1'b1;
            end else begin
               wb_valid = 1'b1;
               wb_sel   = sel_q;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign unit_mode = mode_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_longop_sequencer.sv
// Bench for longop_sequencer: directed cycle checks plus a writeback scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
// Expected writeback selects are queued on accept and popped whenever wb_valid is seen.
module tb_longop_sequencer;

   localparam int NUM_UNITS = 3;
   localparam int MODE_W    = 2;
   localparam int TIMEOUT   = 8;
   localparam int UNIT_W    = $clog2(NUM_UNITS);

   logic                 clk;
   logic                 rst_n;
   logic                 req_valid;
   logic [UNIT_W-1:0]    req_unit;
   logic [MODE_W-1:0]    req_mode;
   logic                 stall;
   logic                 flush;
   logic [NUM_UNITS-1:0] unit_done;
   logic [NUM_UNITS-1:0] unit_start;
   logic [MODE_W-1:0]    unit_mode;
   logic [NUM_UNITS-1:0] unit_abort;
   logic                 pc_hold;
   logic                 wb_valid;
   logic [UNIT_W-1:0]    wb_sel;
   logic                 busy;
   logic                 req_illegal;
`ifdef LONGOP_TIMEOUT_EN
   logic                 err_timeout;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int sb_q[$];

   longop_sequencer #(
      .NUM_UNITS      (NUM_UNITS),
      .MODE_W         (MODE_W),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_unit    (req_unit),
      .req_mode    (req_mode),
      .stall       (stall),
      .flush       (flush),
      .unit_done   (unit_done),
      .unit_start  (unit_start),
      .unit_mode   (unit_mode),
      .unit_abort  (unit_abort),
      .pc_hold     (pc_hold),
      .wb_valid    (wb_valid),
      .wb_sel      (wb_sel),
      .busy        (busy),
`ifdef LONGOP_TIMEOUT_EN
      .req_illegal (req_illegal),
      .err_timeout (err_timeout)
`else
      .req_illegal (req_illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // One clock cycle: apply inputs just after the edge, then let combinational outputs settle.
   task automatic drive(input logic v, input int u, input int m, input logic s, input logic f,
                        input logic [NUM_UNITS-1:0] d);
      @(posedge clk);
      #1;
      req_valid = v;
      req_unit  = UNIT_W'(u);
      req_mode  = MODE_W'(m);
      stall     = s;
      flush     = f;
      unit_done = d;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, '0);
   endtask

   // Scoreboard and invariant monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         check("start_abort_excl", 32'(|(unit_start & unit_abort)), 0);
         if (wb_valid) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_wb", 1, 0);
            end else begin
               int exp_sel;
               exp_sel = sb_q.pop_front();
               check("sb_wb_sel", 32'(wb_sel), exp_sel);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_unit  = '0;
      req_mode  = '0;
      stall     = 1'b0;
      flush     = 1'b0;
      unit_done = '0;
      #3;
      check("rst_busy",       32'(busy), 0);
      check("rst_pc_hold",    32'(pc_hold), 0);
      check("rst_start",      32'(unit_start), 0);
      check("rst_wb_valid",   32'(wb_valid), 0);
      check("rst_unit_mode",  32'(unit_mode), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // MUL: unit 0, done 5 cycles after start, writeback at cycle 7.
      drive(1'b1, 0, 0, 1'b0, 1'b0, '0);
      sb_q.push_back(0);
      check("mul_c0_pc_hold", 32'(pc_hold), 1);
      check("mul_c0_busy",    32'(busy), 0);
      drive(1'b1, 1, 3, 1'b0, 1'b0, '0);
      check("mul_c1_start",   32'(unit_start), 32'b001);
      check("mul_c1_mode",    32'(unit_mode), 0);
      check("mul_c1_pc_hold", 32'(pc_hold), 1);
      for (int c = 2; c <= 5; c++) begin
         idle();
         check("mul_wait_pc_hold", 32'(pc_hold), 1);
         check("mul_wait_wb",      32'(wb_valid), 0);
         check("mul_wait_start",   32'(unit_start), 0);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b001);
      check("mul_c6_pc_hold", 32'(pc_hold), 1);
      check("mul_c6_wb",      32'(wb_valid), 0);
      idle();
      check("mul_c7_wb",      32'(wb_valid), 1);
      check("mul_c7_sel",     32'(wb_sel), 0);
      check("mul_c7_pc_hold", 32'(pc_hold), 0);
      idle();
      check("mul_c8_busy",    32'(busy), 0);
      check("mul_c8_wb",      32'(wb_valid), 0);

      // SDIV with a stray done from unit 0 and two stalled WB cycles.
      drive(1'b1, 1, 1, 1'b0, 1'b0, '0);
      sb_q.push_back(1);
      idle();
      check("div_start", 32'(unit_start), 32'b010);
      check("div_mode",  32'(unit_mode), 1);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b001);
      idle();
      check("div_stray_done_busy", 32'(busy), 1);
      check("div_stray_done_wb",   32'(wb_valid), 0);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b010);
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 0, 0, 1'b1, 1'b0, '0);
         check("div_stall_wb",      32'(wb_valid), 0);
         check("div_stall_pc_hold", 32'(pc_hold), 1);
      end
      idle();
      check("div_wb",      32'(wb_valid), 1);
      check("div_wb_sel",  32'(wb_sel), 1);
      idle();
      check("div_after_wb", 32'(wb_valid), 0);
      check("div_after_busy", 32'(busy), 0);

      // Flush coincident with the selected done during WAIT.
      drive(1'b1, 1, 2, 1'b0, 1'b0, '0);
      idle();
      idle();
      drive(1'b0, 0, 0, 1'b0, 1'b1, 3'b010);
      check("flush_abort", 32'(unit_abort), 32'b010);
      check("flush_wb",    32'(wb_valid), 0);
      idle();
      check("flush_busy",  32'(busy), 0);
      check("flush_wb_next", 32'(wb_valid), 0);

      // Flush in START aborts instead of starting.
      drive(1'b1, 2, 3, 1'b0, 1'b0, '0);
      drive(1'b0, 0, 0, 1'b0, 1'b1, '0);
      check("flush_start_abort", 32'(unit_abort), 32'b100);
      check("flush_start_start", 32'(unit_start), 0);
      idle();
      check("flush_start_busy", 32'(busy), 0);

      // Flush in a stalled WB suppresses writeback.
      drive(1'b1, 0, 0, 1'b0, 1'b0, '0);
      idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b001);
      drive(1'b0, 0, 0, 1'b1, 1'b1, '0);
      check("flush_wb_state_wb", 32'(wb_valid), 0);
      idle();
      check("flush_wb_busy", 32'(busy), 0);
      check("flush_wb_none", 32'(wb_valid), 0);

      // Illegal unit index, and stall/flush blocking acceptance.
      drive(1'b1, 3, 0, 1'b0, 1'b0, '0);
      check("ill_flag",    32'(req_illegal), 1);
      check("ill_pc_hold", 32'(pc_hold), 0);
      idle();
      check("ill_busy",    32'(busy), 0);
      check("ill_start",   32'(unit_start), 0);
      check("ill_flag_clr", 32'(req_illegal), 0);
      drive(1'b1, 0, 0, 1'b1, 1'b0, '0);
      check("stall_idle_pc_hold", 32'(pc_hold), 0);
      drive(1'b1, 1, 0, 1'b0, 1'b1, '0);
      check("stall_idle_busy", 32'(busy), 0);
      idle();
      check("flush_idle_busy", 32'(busy), 0);

      // Reset mid-WAIT drops the op, then a minimum-latency op completes.
      drive(1'b1, 1, 1, 1'b0, 1'b0, '0);
      idle();
      idle();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("rst_mid_busy",    32'(busy), 0);
      check("rst_mid_pc_hold", 32'(pc_hold), 0);
      check("rst_mid_abort",   32'(unit_abort), 0);
      check("rst_mid_mode",    32'(unit_mode), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 0, 2, 1'b0, 1'b0, '0);
      sb_q.push_back(0);
      check("min_c0_pc_hold", 32'(pc_hold), 1);
      idle();
      check("min_c1_start", 32'(unit_start), 32'b001);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b001);
      check("min_c2_wb", 32'(wb_valid), 0);
      idle();
      check("min_c3_wb", 32'(wb_valid), 1);
      idle();
      check("min_c4_busy", 32'(busy), 0);

`ifdef LONGOP_TIMEOUT_EN
      // Watchdog: no done, abort 8 cycles after entering WAIT, sticky error.
      check("to_err_init", 32'(err_timeout), 0);
      drive(1'b1, 0, 1, 1'b0, 1'b0, '0);
      idle();
      for (int k = 0; k < TIMEOUT; k++) begin
         idle();
         check("to_wait_abort", 32'(unit_abort), 0);
         check("to_wait_busy",  32'(busy), 1);
      end
      idle();
      check("to_abort",    32'(unit_abort), 32'b001);
      check("to_abort_wb", 32'(wb_valid), 0);
      idle();
      check("to_busy", 32'(busy), 0);
      check("to_err",  32'(err_timeout), 1);
      drive(1'b1, 1, 0, 1'b0, 1'b0, '0);
      sb_q.push_back(1);
      idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 3'b010);
      idle();
      check("to_next_wb", 32'(wb_valid), 1);
      idle();
      check("to_err_sticky", 32'(err_timeout), 1);
`endif

      idle();
      idle();
      check("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
